// File: rtl/stm_sequencer.sv
// Store-multiple sequencer: walks a 16-bit register list lowest-first, driving the read-mux
// select and streaming each word to the data-memory write port with ARM-style addressing.
module stm_sequencer #(
  parameter int unsigned STRIDE = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] reg_list_i,
  input  logic [31:0] base_addr_i,
  input  logic        up_i,
  input  logic        pre_i,
  output logic [3:0]  read_register_o,
  input  logic [31:0] read_data_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic        mem_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] final_addr_o
);

  localparam logic [31:0] StrideW = 32'(STRIDE);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e      state_q;
  logic [15:0] remaining_q;
  logic [31:0] mem_addr_q;
  logic [31:0] final_addr_q;
  logic [3:0]  read_register_q;
  logic        mem_we_q;
  logic        busy_q;
  logic        done_q;

  logic [4:0]  count;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] final_next;
  logic [15:0] rem_next;

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(reg_list_i[i]);
    end
  end

  assign span = StrideW * 32'(count);

  // The block always occupies [lowest, lowest + span) so the lowest register lands lowest.
  always_comb begin
    start_addr = base_addr_i;
    unique case ({up_i, pre_i})
      2'b10:   start_addr = base_addr_i;
      2'b11:   start_addr = base_addr_i + StrideW;
      2'b00:   start_addr = base_addr_i - span + StrideW;
      2'b01:   start_addr = base_addr_i - span;
      default: start_addr = base_addr_i;
    endcase
  end

  assign final_next = up_i ? (base_addr_i + span) : (base_addr_i - span);
  assign rem_next   = remaining_q & (remaining_q - 16'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      remaining_q     <= 16'd0;
      mem_addr_q      <= 32'd0;
      final_addr_q    <= 32'd0;
      read_register_q <= 4'd0;
      mem_we_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            remaining_q  <= reg_list_i;
            mem_addr_q   <= start_addr;
            final_addr_q <= final_next;
            busy_q       <= 1'b1;
            if (count == 5'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q         <= StXfer;
              mem_we_q        <= 1'b1;
              read_register_q <= lowest_idx(reg_list_i);
            end
          end
        end
        StXfer: begin
          if (mem_ready_i) begin
            remaining_q     <= rem_next;
            mem_addr_q      <= mem_addr_q + StrideW;
            read_register_q <= lowest_idx(rem_next);
            if (rem_next == 16'd0) begin
              state_q  <= StDone;
              mem_we_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign read_register_o = read_register_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = read_data_i;
  assign mem_we_o        = mem_we_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign final_addr_o    = final_addr_q;

endmodule

// File: tb/tb_stm_sequencer.sv
// Self-checking bench for stm_sequencer: directed addressing-mode cases, stalls, reset,
// back-to-back commands and randomized commands against a list/arithmetic reference model.
module tb_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] reg_list = 16'd0;
  logic [31:0] base = 32'd0;
  logic        up = 1'b1;
  logic        pre = 1'b0;
  logic [3:0]  rd_reg;
  logic [31:0] rd_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] final_addr;

  logic [31:0] regs [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_reg];

  stm_sequencer #(.STRIDE(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .reg_list_i     (reg_list),
    .base_addr_i    (base),
    .up_i           (up),
    .pre_i          (pre),
    .read_register_o(rd_reg),
    .read_data_i    (rd_data),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_we_o       (mem_we),
    .mem_ready_i    (mem_ready),
    .busy_o         (busy),
    .done_o         (done),
    .final_addr_o   (final_addr)
  );

  // Observations from the most recent command.
  logic [31:0] cap_addr [$];
  logic [31:0] cap_data [$];
  logic [3:0]  cap_reg  [$];
  int          cap_done_cyc;
  int          cap_done_cnt;
  int          cap_we_cyc;
  bit          cap_timeout;
  logic [31:0] cap_final;
  logic        cap_done_busy;
  logic        cap_done_we;
  logic        cap_pre_busy;
  logic        cap_pre_done;
  logic [31:0] cap_pre_final;
  logic [3:0]  cyc_reg  [64];
  logic [31:0] cyc_addr [64];
  logic [31:0] cyc_data [64];
  logic        cyc_we   [64];

  function automatic int popcnt(input logic [15:0] l);
    int n = 0;
    for (int i = 0; i < 16; i++) if (l[i]) n++;
    return n;
  endfunction

  // Block spans STRIDE*n bytes; its lowest address depends on direction and pre/post.
  function automatic logic [31:0] model_lowest(input logic [15:0] l, input logic [31:0] b,
                                                input logic u, input logic p);
    logic [31:0] span = 32'(4 * popcnt(l));
    if (u) return p ? b + 32'd4 : b;
    return p ? b - span : b - span + 32'd4;
  endfunction

  function automatic logic [31:0] model_final(input logic [15:0] l, input logic [31:0] b,
                                               input logic u);
    logic [31:0] span = 32'(4 * popcnt(l));
    return u ? b + span : b - span;
  endfunction

  function automatic int model_done_cyc(input logic [15:0] l, input logic [63:0] m);
    int c = 1;
    for (int k = 0; k < popcnt(l); k++) begin
      while (c < 64 && m[c]) c++;
      c++;
    end
    return c;
  endfunction

  task automatic run_cmd(input logic [15:0] c_list, input logic [31:0] c_base, input logic c_up,
                         input logic c_pre, input logic [63:0] stall_mask, input bit pulse);
    int c;
    bit seen;
    cap_addr.delete();
    cap_data.delete();
    cap_reg.delete();
    cap_done_cyc = -1;
    cap_done_cnt = 0;
    cap_we_cyc = 0;
    cap_timeout = 0;
    cap_final = 32'hx;
    cap_done_busy = 1'bx;
    cap_done_we = 1'bx;
    @(negedge clk);
    cap_pre_busy = busy;
    cap_pre_done = done;
    cap_pre_final = final_addr;
    start = 1'b1;
    reg_list = c_list;
    base = c_base;
    up = c_up;
    pre = c_pre;
    mem_ready = 1'b0;
    c = 0;
    seen = 0;
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (pulse && c == 1) begin
        start = 1'b1;
        reg_list = ~c_list;
        base = ~c_base;
        up = ~c_up;
        pre = ~c_pre;
      end else begin
        start = 1'b0;
      end
      mem_ready = (c < 64) ? !stall_mask[6'(c)] : 1'b1;
      #1;
      if (c < 64) begin
        cyc_reg[c] = rd_reg;
        cyc_addr[c] = mem_addr;
        cyc_data[c] = mem_wdata;
        cyc_we[c] = mem_we;
      end
      if (mem_we) begin
        cap_we_cyc++;
        if (mem_ready) begin
          cap_addr.push_back(mem_addr);
          cap_data.push_back(mem_wdata);
          cap_reg.push_back(rd_reg);
        end
      end
      if (done) begin
        cap_done_cnt++;
        cap_done_cyc = c;
        cap_final = final_addr;
        cap_done_busy = busy;
        cap_done_we = mem_we;
        seen = 1;
      end
    end
    if (!seen) cap_timeout = 1;
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_we, busy, done, rd_reg, mem_addr, final_addr} !== 71'd0) begin
      failures++;
      $display("FAIL reset_state: got we=%b busy=%b done=%b reg=%0d addr=%h final=%h required 0",
               mem_we, busy, done, rd_reg, mem_addr, final_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    reg_list = 16'hFFFF;
    base = 32'h1000;
    up = 1'b1;
    pre = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_xfer: got we=%b busy=%b required 1 1", mem_we, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, busy, done, rd_reg, mem_addr, final_addr} !== 71'd0) begin
      failures++;
      $display("FAIL reset_async: got we=%b busy=%b done=%b reg=%0d addr=%h final=%h required 0",
               mem_we, busy, done, rd_reg, mem_addr, final_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (mem_we !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_resume: cycle %0d got we=%b busy=%b required 0 0", i, mem_we, busy);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] lists  [6] = '{16'h0005, 16'h8003, 16'h0010, 16'h0010, 16'h0000, 16'h000F};
    logic [31:0] bases  [6] = '{32'h100, 32'h200, 32'h40, 32'h40, 32'h80, 32'hFFFFFFF8};
    logic        ups    [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        pres   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] firsts [6] = '{32'h100, 32'h1F4, 32'h44, 32'h40, 32'h0, 32'hFFFFFFF8};
    logic [31:0] finals [6] = '{32'h108, 32'h1F4, 32'h44, 32'h3C, 32'h80, 32'h8};
    int          ns     [6] = '{2, 3, 1, 1, 0, 4};
    for (int t = 0; t < 6; t++) begin
      int k;
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      regs[0] = 32'hAAAAAAAA;
      regs[2] = 32'h22222222;
      run_cmd(lists[t], bases[t], ups[t], pres[t], 64'd0, 1'b0);
      checks++;
      if (cap_timeout || cap_done_cyc != ns[t] + 1) begin
        failures++;
        $display("FAIL dir%0d_done_cycle: got %0d required %0d", t, cap_done_cyc, ns[t] + 1);
      end
      checks++;
      if (cap_addr.size() != ns[t] || cap_we_cyc != ns[t]) begin
        failures++;
        $display("FAIL dir%0d_write_count: got %0d writes %0d we-cycles required %0d",
                 t, cap_addr.size(), cap_we_cyc, ns[t]);
      end
      k = 0;
      for (int i = 0; i < 16; i++) begin
        if (lists[t][i] && k < cap_addr.size()) begin
          checks++;
          if (cap_reg[k] !== 4'(i) || cap_addr[k] !== firsts[t] + 32'(4 * k) ||
              cap_data[k] !== regs[i]) begin
            failures++;
            $display("FAIL dir%0d_word%0d: got R%0d@%h=%h required R%0d@%h=%h", t, k, cap_reg[k],
                     cap_addr[k], cap_data[k], i, firsts[t] + 32'(4 * k), regs[i]);
          end
          k++;
        end
      end
      checks++;
      if (cap_final !== finals[t] || cap_done_cnt != 1 || cap_done_busy !== 1'b1 ||
          cap_done_we !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_final: got %h (busy=%b we=%b) required %h busy=1 we=0",
                 t, cap_final, cap_done_busy, cap_done_we, finals[t]);
      end
    end
    checks++;
    if (regs[0] !== 32'hAAAAAAAA || lists[0] !== 16'h0005) begin
      failures++;
      $display("FAIL dir_table: regs corrupted");
    end
  endtask

  task automatic test_stall();
    logic [63:0] m = 64'd0;
    m[2] = 1'b1;
    m[3] = 1'b1;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    run_cmd(16'h0003, 32'h300, 1'b1, 1'b0, m, 1'b0);
    checks++;
    if (cap_done_cyc != 5) begin
      failures++;
      $display("FAIL stall_done_cycle: got %0d required 5", cap_done_cyc);
    end
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if (cyc_we[c] !== 1'b1 || cyc_reg[c] !== 4'd1 || cyc_addr[c] !== 32'h304 ||
          cyc_data[c] !== regs[1]) begin
        failures++;
        $display("FAIL stall_hold_c%0d: got we=%b R%0d@%h=%h required we=1 R1@304=%h",
                 c, cyc_we[c], cyc_reg[c], cyc_addr[c], cyc_data[c], regs[1]);
      end
    end
    checks++;
    if (cap_addr.size() != 2 || cap_we_cyc != 4) begin
      failures++;
      $display("FAIL stall_counts: got %0d writes %0d we-cycles required 2 4",
               cap_addr.size(), cap_we_cyc);
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    run_cmd(16'h0180, 32'h500, 1'b1, 1'b1, 64'd0, 1'b1);
    checks++;
    if (cap_addr.size() != 2 || cap_addr[0] !== 32'h504 || cap_reg[0] !== 4'd7 ||
        cap_addr[1] !== 32'h508 || cap_reg[1] !== 4'd8 || cap_done_cyc != 3 ||
        cap_final !== 32'h508) begin
      failures++;
      $display("FAIL start_ignored: got %0d writes done=%0d final=%h required 2 writes done=3 final=508",
               cap_addr.size(), cap_done_cyc, cap_final);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_final;
    run_cmd(16'h0001, 32'h600, 1'b1, 1'b0, 64'd0, 1'b0);
    prev_final = cap_final;
    run_cmd(16'h0006, 32'h700, 1'b0, 1'b1, 64'd0, 1'b0);
    checks++;
    if (cap_pre_busy !== 1'b0 || cap_pre_done !== 1'b0 || cap_pre_final !== prev_final ||
        prev_final !== 32'h604) begin
      failures++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b final=%h/%h required 0 0 604",
               cap_pre_busy, cap_pre_done, cap_pre_final, prev_final);
    end
    checks++;
    if (cap_done_cyc != 3 || cap_addr.size() != 2 || cap_addr[0] !== 32'h6F8 ||
        cap_addr[1] !== 32'h6FC || cap_final !== 32'h6F8) begin
      failures++;
      $display("FAIL b2b_second: got done=%0d writes=%0d final=%h required 3 2 6F8",
               cap_done_cyc, cap_addr.size(), cap_final);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [15:0] l;
      logic [31:0] b;
      logic        u, p;
      logic [63:0] m;
      logic [3:0]  exp_reg [$];
      int          sel;
      sel = int'($urandom_range(7));
      l = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(31)) : $urandom;
      u = 1'($urandom_range(1));
      p = 1'($urandom_range(1));
      for (int i = 0; i < 64; i++) m[i] = ($urandom_range(3) == 0);
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      for (int i = 0; i < 16; i++) if (l[i]) exp_reg.push_back(4'(i));
      run_cmd(l, b, u, p, m, 1'($urandom_range(1)));
      checks++;
      if (cap_timeout || cap_done_cyc != model_done_cyc(l, m) ||
          cap_we_cyc != model_done_cyc(l, m) - 1 || cap_pre_busy !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_timing: got done=%0d we=%0d required done=%0d list=%h",
                 it, cap_done_cyc, cap_we_cyc, model_done_cyc(l, m), l);
      end
      checks++;
      if (cap_addr.size() != exp_reg.size() || cap_final !== model_final(l, b, u)) begin
        failures++;
        $display("FAIL rnd%0d_final: got %0d writes final=%h required %0d final=%h",
                 it, cap_addr.size(), cap_final, exp_reg.size(), model_final(l, b, u));
      end
      for (int k = 0; k < exp_reg.size() && k < cap_addr.size(); k++) begin
        checks++;
        if (cap_reg[k] !== exp_reg[k] || cap_data[k] !== regs[exp_reg[k]] ||
            cap_addr[k] !== model_lowest(l, b, u, p) + 32'(4 * k)) begin
          failures++;
          $display("FAIL rnd%0d_word%0d: got R%0d@%h=%h required R%0d@%h=%h", it, k, cap_reg[k],
                   cap_addr[k], cap_data[k], exp_reg[k], model_lowest(l, b, u, p) + 32'(4 * k),
                   regs[exp_reg[k]]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    test_reset();
    test_directed();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stm_sequencer.md
# stm_sequencer

Store-multiple sequencer for the 16 x 32-bit register file read path. On a command it walks a 16-bit register list from lowest to highest index. For each listed register it drives the read-mux select, forwards the selected word to the data-memory write port with an ARM-style computed address, and reports the base-register writeback value on completion. It sits between the instruction decode/control unit and the register read mux / data memory.

## Interface
Parameters:
- STRIDE, 4, byte increment between consecutive words.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the block to IDLE immediately.
- start  in  1  command strobe; sampled only in IDLE.
- reg_list  in  16  bit i set = store Ri; sampled with start.
- base_addr  in  32  base register value; sampled with start.
- up  in  1  1 = increment (U bit), 0 = decrement; sampled with start.
- pre  in  1  1 = adjust before transfer (P bit), 0 = after; sampled with start.
- readRegister  out  4  select to register read mux.
- readData  in  32  word returned by read mux for readRegister (combinational).
- mem_addr  out  32  byte address of current write.
- mem_wdata  out  32  write data; combinational copy of readData.
- mem_we  out  1  write request; high for the whole XFER state.
- mem_ready  in  1  memory accepts the current write in a cycle where mem_we and mem_ready are both 1.
- busy  out  1  high in XFER and DONE.
- done  out  1  single-cycle completion pulse.
- final_addr  out  32  writeback value for base register; valid from DONE, held until next accepted start.

## Operation
- States: IDLE, XFER, DONE.
- IDLE, start=1: latch reg_list into remaining, compute n = popcount(reg_list), 0..16.
  - n=0 -> DONE, with final_addr = base_addr.
  - Otherwise -> XFER.
  - mem_addr loads the start address.
- Start address by mode, modulo 2^32:
  - IA (up=1, pre=0): base.
  - IB (up=1, pre=1): base+STRIDE.
  - DA (up=0, pre=0): base-STRIDE*n+STRIDE.
  - DB (up=0, pre=1): base-STRIDE*n.
- final_addr: base+STRIDE*n if up, else base-STRIDE*n. Computed at start.
- Lowest register always goes to lowest address, regardless of direction.
- XFER:
  - readRegister = index of lowest set bit of remaining.
  - mem_we=1; mem_addr is registered.
  - On mem_ready=1: clear that bit and add STRIDE to mem_addr.
  - If remaining becomes zero -> DONE.
  - On mem_ready=0: readRegister, mem_addr and mem_we hold.
- DONE: done=1 for one cycle -> IDLE.
- start is ignored outside IDLE.
- In IDLE: readRegister=0, mem_we=0, and mem_addr holds its last value.
- Address arithmetic wraps modulo 2^32 with no error indication.

## Timing
- Reset values: state IDLE, readRegister 0, mem_addr 0, mem_we 0, busy 0, done 0, final_addr 0, remaining 0.
- Reset mid-operation: mem_we and busy drop asynchronously. No further writes occur, and the command is lost.
- Start accepted at edge k:
  - First write presented in cycle k+1.
  - With mem_ready held high, word j is written in cycle k+j. DONE (done=1) is in cycle k+n+1, and IDLE is in cycle k+n+2.
- Empty list: DONE in cycle k+1 with no mem_we.
- Each mem_ready=0 cycle in XFER adds exactly one cycle of latency.
- start may be reasserted in the first IDLE cycle after DONE. Back-to-back commands need no gap beyond that.
- mem_wdata follows readData combinationally, with zero cycles of latency from readRegister.

## Test plan
- Reset: assert reset=0 mid-XFER. Required: mem_we=0 and busy=0 immediately; all outputs at reset values; no writes after release until a new start.
- IA: list 0x0005, base 0x100, R0=0xAAAAAAAA, R2=0x22222222, ready=1. Required: (0x100, 0xAAAAAAAA), then (0x104, 0x22222222); done in cycle 3; final_addr 0x108.
- DB: list 0x8003, base 0x200. Required: R0@0x1F4, R1@0x1F8, R15@0x1FC; final_addr 0x1F4.
- IB/DA: list 0x0010, base 0x40. Required for IB: R4@0x44, final 0x44. Required for DA: R4@0x40, final 0x3C.
- Stall: IA list 0x0003; mem_ready=0 for 2 cycles on the second word. Required: readRegister=1, mem_addr and mem_wdata stable throughout; done 2 cycles later than unstalled.
- Edge cases:
  - Empty list, base 0x80. Required: done in cycle 1, no mem_we, final 0x80.
  - start pulsed during XFER. Required: ignored.
  - IA list 0x000F, base 0xFFFFFFF8. Required: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; final 0x8.
